acc_eng_ctrl_mc: RTL
====================

# acc_eng_ctrl_mc

Multi-engine ap_ctrl_chain controller for the convolution accelerator: the generalised successor to the single-engine start/done controller. It accepts kernel starts from the host handshake and dispatches them round-robin to `NUM_ENG` convolution engines, allowing up to `NUM_ENG` jobs in flight. It reports `ap_done` strictly in dispatch order, each report held until `ap_continue`. It sits between the kernel control interface and the engine array, next to the AXI write master.

## Interface
- `NUM_ENG`, default 4: number of engines, 1..16.
- `PTR_W`, default `$clog2(NUM_ENG)` (minimum 1): width of the dispatch and done pointers.
- `CNT_W`, default `$clog2(NUM_ENG+1)`: width of the outstanding-job count.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ap_start` in 1: host start request.
- `ap_continue` in 1: host acknowledges `ap_done`.
- `ap_ready` out 1: a start is accepted this cycle if `ap_start` is high.
- `ap_done` out 1: the oldest job has finished; held until `ap_continue`.
- `ap_idle` out 1: no job is in flight and none is pending report.
- `op_start` out NUM_ENG: one-cycle start pulse, one bit per engine.
- `end_conv` in NUM_ENG: engine i has finished computing (pulse or level).
- `write_buffer_wait` in NUM_ENG: engine i's write buffer is not yet drained.
- `wmst_done` in 1: AXI write master finished a burst sequence.
- `eng_busy` out NUM_ENG: engine i is not IDLE.
- `outstanding` out CNT_W: number of engines not IDLE.

## Operation
- Each engine slot has its own FSM: IDLE → LAUNCH → BUSY → FLUSH → DONE → IDLE.
  - IDLE → LAUNCH: the slot is at `wr_ptr` and `ap_start && ap_ready`.
  - LAUNCH → BUSY: unconditional, one cycle; `op_start[i]` is high only in LAUNCH.
  - BUSY → FLUSH: `end_conv[i]` is high.
  - FLUSH → DONE: `!write_buffer_wait[i]`, subject to the Configuration gate.
  - DONE → IDLE: the slot is at `rd_ptr` and `ap_done && ap_continue`.
- `ap_ready` = (slot at `wr_ptr` is IDLE). This is combinational from state and independent of `ap_start`.
- `ap_done` = (slot at `rd_ptr` is DONE). It is decoded from registered state only.
- `ap_idle` = all slots IDLE.
- `wr_ptr` increments on each accepted start. `rd_ptr` increments on each `ap_done && ap_continue`. Both wrap from NUM_ENG-1 to 0.
- `outstanding` = count of non-IDLE slots. It is registered: +1 on accept, −1 on pop, unchanged when both happen in the same cycle.
- `end_conv[i]` is ignored outside BUSY, including in LAUNCH.
- `write_buffer_wait[i]` is ignored outside FLUSH.
- Completions may arrive out of order. A slot that reaches DONE out of order waits there until `rd_ptr` reaches it.

## Timing
- Reset values: `op_start`=0, `eng_busy`=0, `outstanding`=0, `ap_done`=0, `ap_ready`=1, `ap_idle`=1, `wr_ptr`=`rd_ptr`=0, all slots IDLE.
- `ap_start` accepted at cycle T → `op_start[wr_ptr]` high at T+1 only → BUSY at T+2.
- `end_conv` at cycle T with `write_buffer_wait` low → FLUSH at T+1 → DONE at T+2 → `ap_done` high at T+2 if the slot is the head.
- `ap_done && ap_continue` at cycle T → slot IDLE and `rd_ptr`+1 at T+1. If the next slot is already DONE, `ap_done` stays high at T+1 with no gap.
- Ring full (all slots non-IDLE): `ap_ready`=0.
  - If the pop and `ap_start` occur in the same cycle, the start is not taken that cycle.
  - `ap_ready` rises one cycle after the pop.
- `ap_continue` without `ap_done` is ignored.
- `rst_n` low mid-job: everything returns immediately to reset values, any `op_start` pulse in progress is cut off, and pending completions are discarded.

## Configuration
- `ACC_ENG_WMST_GATE_EN` defined:
  - Each slot has a sticky `wmst_seen` bit, set by `wmst_done` while the slot is BUSY or FLUSH and cleared on entering LAUNCH.
  - FLUSH → DONE additionally requires `wmst_seen`, or `wmst_done` high in the same cycle.
- `ACC_ENG_WMST_GATE_EN` undefined: `wmst_done` is ignored, no sticky bits are built, and FLUSH → DONE depends only on `write_buffer_wait`.

## Test plan
- Reset then a single job, NUM_ENG=4: `ap_start` at cycle 10 → `op_start`=4'b0001 at 11; `end_conv[0]` at 20 → `ap_done` at 22; `ap_continue` at 25 → `ap_idle`=1 at 26.
- Four back-to-back starts → `op_start` pulses 0001, 0010, 0100, 1000 on consecutive cycles; `outstanding`=4; `ap_ready`=0.
- Out-of-order finish: `end_conv[2]` before `end_conv[0]` → `ap_done` only after engine 0 reaches DONE; two `ap_continue` pulses retire engine 0, then engine 1 is awaited.
- `write_buffer_wait[0]` held high for 7 cycles after `end_conv[0]` → `ap_done` delayed exactly 7 cycles relative to the no-wait case.
- Full ring with `ap_start` and `ap_continue` in the same cycle → no `op_start` that cycle; accepted one cycle later into slot 0.
- With `ACC_ENG_WMST_GATE_EN`: `end_conv` and no `wmst_done` → `ap_done` stays 0. A `wmst_done` pulse then gives `ap_done` one cycle later (DONE at the next edge). Without the macro, the same stimulus gives `ap_done` as in the first scenario.

Source files
------------

// File: rtl/acc_eng_ctrl_mc_if.sv
// Host-side ap_ctrl_chain handshake for the multi-engine accelerator controller.
// The host drives start/continue; the controller reports ready/done/idle.
interface acc_eng_ctrl_mc_if;
  logic ap_start;
  logic ap_continue;
  logic ap_ready;
  logic ap_done;
  logic ap_idle;

  modport master (
    output ap_start, ap_continue,
    input  ap_ready, ap_done, ap_idle
  );

  modport slave (
    input  ap_start, ap_continue,
    output ap_ready, ap_done, ap_idle
  );
endinterface

// File: rtl/acc_eng_ctrl_mc.sv
// Round-robin dispatcher for NUM_ENG convolution engines with in-order ap_done reporting.
// Optional ACC_ENG_WMST_GATE_EN also holds FLUSH until the AXI write master reports wmst_done.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | slot free, may accept the next start when at wr_ptr
// S_LAUNCH | one-cycle op_start pulse to the engine
// S_BUSY   | engine computing, waiting for end_conv
// S_FLUSH  | waiting for the engine write buffer to drain
// S_DONE   | finished, waiting to be reported and popped at rd_ptr
module acc_eng_ctrl_mc #(
  parameter int NUM_ENG = 4,
  parameter int PTR_W   = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1,
  parameter int CNT_W   = $clog2(NUM_ENG + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  acc_eng_ctrl_mc_if.slave   host,
  output logic [NUM_ENG-1:0] op_start,
  input  logic [NUM_ENG-1:0] end_conv,
  input  logic [NUM_ENG-1:0] write_buffer_wait,
  input  logic               wmst_done,
  output logic [NUM_ENG-1:0] eng_busy,
  output logic [CNT_W-1:0]   outstanding
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_BUSY   = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } slot_state_e;

  slot_state_e        state_q [NUM_ENG];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [NUM_ENG-1:0] slot_idle;
  logic [NUM_ENG-1:0] slot_done;
  logic [NUM_ENG-1:0] flush_ok;
  logic               accept;
  logic               pop;

  always_comb begin
    slot_idle = '0;
    slot_done = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      slot_idle[i] = (state_q[i] == S_IDLE);
      slot_done[i] = (state_q[i] == S_DONE);
    end
  end

  // Both flags come from registered slot state only, never from ap_start/ap_continue.
  assign host.ap_ready = slot_idle[wr_ptr];
  assign host.ap_done  = slot_done[rd_ptr];
  assign host.ap_idle  = &slot_idle;

  assign accept = host.ap_start && host.ap_ready;
  assign pop    = host.ap_done && host.ap_continue;

`ifdef ACC_ENG_WMST_GATE_EN
  logic [NUM_ENG-1:0] wmst_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wmst_seen <= '0;
    end else begin
      for (int i = 0; i < NUM_ENG; i++) begin
        if (state_q[i] == S_IDLE && accept && wr_ptr == PTR_W'(i)) begin
          wmst_seen[i] <= 1'b0;
        end else if (wmst_done && (state_q[i] == S_BUSY || state_q[i] == S_FLUSH)) begin
          wmst_seen[i] <= 1'b1;
        end
      end
    end
  end

  assign flush_ok = ~write_buffer_wait & (wmst_seen | {NUM_ENG{wmst_done}});
`else
  logic unused_wmst_done;
  assign unused_wmst_done = wmst_done;
  assign flush_ok = ~write_buffer_wait;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENG; i++) begin
        state_q[i] <= S_IDLE;
      end
      op_start    <= '0;
      eng_busy    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      for (int i = 0; i < NUM_ENG; i++) begin
        op_start[i] <= 1'b0;
        unique case (state_q[i])
          S_IDLE: begin
            if (accept && wr_ptr == PTR_W'(i)) begin
              state_q[i]  <= S_LAUNCH;
              op_start[i] <= 1'b1;
              eng_busy[i] <= 1'b1;
            end
          end
          S_LAUNCH: state_q[i] <= S_BUSY;
          S_BUSY: begin
            if (end_conv[i]) state_q[i] <= S_FLUSH;
          end
          S_FLUSH: begin
            if (flush_ok[i]) state_q[i] <= S_DONE;
          end
          S_DONE: begin
            if (pop && rd_ptr == PTR_W'(i)) begin
              state_q[i]  <= S_IDLE;
              eng_busy[i] <= 1'b0;
            end
          end
          default: begin
            state_q[i]  <= S_IDLE;
            eng_busy[i] <= 1'b0;
          end
        endcase
      end

      if (accept) begin
        wr_ptr <= (wr_ptr == PTR_W'(NUM_ENG - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(NUM_ENG - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end

      if (accept && !pop) begin
        outstanding <= outstanding + CNT_W'(1);
      end else if (pop && !accept) begin
        outstanding <= outstanding - CNT_W'(1);
      end
    end
  end

endmodule
